// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: BLOCK-bit select blocks, a register
// stage after every BLOCKS_PER_STAGE blocks, valid/ready handshake at both ends.
module pipelined_carry_select_adder #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned BLOCK            = 4,
  parameter int unsigned BLOCKS_PER_STAGE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     carry_in,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     carry_out,
  output logic                     overflow,
  output logic [WIDTH/BLOCK-1:0]   block_carries
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned L    = NBLK / BLOCKS_PER_STAGE;
  localparam int unsigned SW   = BLOCK * BLOCKS_PER_STAGE;
  localparam int unsigned BW   = BLOCK + 1;

  // Operands are kept right-aligned: each stage consumes the low SW bits and
  // shifts the rest down. Finished sum bits and carries enter from the top.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             sign_a;
    logic             sign_b;
    logic             ovf;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [NBLK-1:0]  bc;
  } stage_t;

  stage_t                      stage_in  [L];
  stage_t                      stage_nxt [L];
  stage_t                      stage_q   [L];
  logic                        advance;
  logic                        c;
  logic [BW-1:0]               r0;
  logic [BW-1:0]               r1;
  logic [BW-1:0]               rsel;
  logic [SW-1:0]               ssum;
  logic [BLOCKS_PER_STAGE-1:0] sbc;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage inputs and carry-select evaluation of every stage.
  always_comb begin
    c    = 1'b0;
    r0   = '0;
    r1   = '0;
    rsel = '0;
    ssum = '0;
    sbc  = '0;

    stage_in[0].valid  = in_valid;
    stage_in[0].carry  = sub | carry_in;
    stage_in[0].sign_a = a[WIDTH-1];
    stage_in[0].sign_b = b[WIDTH-1] ^ sub;
    stage_in[0].ovf    = 1'b0;
    stage_in[0].opa    = a;
    stage_in[0].opb    = sub ? ~b : b;
    stage_in[0].res    = '0;
    stage_in[0].bc     = '0;
    for (int unsigned s = 1; s < L; s++) begin
      stage_in[s] = stage_q[s-1];
    end

    for (int unsigned s = 0; s < L; s++) begin
      stage_nxt[s] = stage_in[s];
      c    = stage_in[s].carry;
      ssum = '0;
      sbc  = '0;
      for (int unsigned k = 0; k < BLOCKS_PER_STAGE; k++) begin
        r0   = BW'(stage_in[s].opa[k*BLOCK +: BLOCK]) + BW'(stage_in[s].opb[k*BLOCK +: BLOCK]);
        r1   = r0 + BW'(1);
        rsel = c ? r1 : r0;
        ssum[k*BLOCK +: BLOCK] = rsel[BLOCK-1:0];
        c      = rsel[BLOCK];
        sbc[k] = c;
      end
      stage_nxt[s].carry = c;
      stage_nxt[s].opa   = stage_in[s].opa >> SW;
      stage_nxt[s].opb   = stage_in[s].opb >> SW;
      stage_nxt[s].res   = (stage_in[s].res >> SW) | (WIDTH'(ssum) << (WIDTH - SW));
      stage_nxt[s].bc    = (stage_in[s].bc >> BLOCKS_PER_STAGE)
                         | (NBLK'(sbc) << (NBLK - BLOCKS_PER_STAGE));
      // Only meaningful once the top bit is final, i.e. in the last stage.
      stage_nxt[s].ovf   = (stage_in[s].sign_a == stage_in[s].sign_b)
                         && (stage_nxt[s].res[WIDTH-1] != stage_in[s].sign_a);
    end
  end

  // Pipeline registers: whole pipe shifts together on advance, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < L; s++) begin
        stage_q[s] <= '0;
      end
    end else if (advance) begin
      for (int unsigned s = 0; s < L; s++) begin
        stage_q[s] <= stage_nxt[s];
      end
    end
  end

  assign out_valid     = stage_q[L-1].valid;
  assign sum           = stage_q[L-1].res;
  assign carry_out     = stage_q[L-1].carry;
  assign overflow      = stage_q[L-1].ovf;
  assign block_carries = stage_q[L-1].bc;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed-vector and scoreboard bench for pipelined_carry_select_adder,
// default 16/4/1 instance plus a 32/8/2 instance.
module tb_pipelined_carry_select_adder;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic [3:0]  bc;
  } vec_t;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic [7:0]  bc;
  } exp_t;

  localparam int NV = 10;

  logic        clk;
  logic        rst;
  logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_co, n_ov;
  logic [15:0] n_a, n_b, n_sum;
  logic [3:0]  n_bc;
  logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_co, w_ov;
  logic [31:0] w_a, w_b, w_sum;
  logic [3:0]  w_bc;

  int   errors;
  int   checks;
  vec_t vecs [NV];
  exp_t e;

  pipelined_carry_select_adder dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .carry_in(n_cin), .sub(n_sub),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .sum(n_sum),
    .carry_out(n_co), .overflow(n_ov), .block_carries(n_bc)
  );

  pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(8), .BLOCKS_PER_STAGE(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .carry_in(w_cin), .sub(w_sub),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .sum(w_sum),
    .carry_out(w_co), .overflow(w_ov), .block_carries(w_bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: whole-word sum plus per-prefix sums for block carries.
  function automatic exp_t model(input int unsigned w, input int unsigned blk,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t r;
    logic [63:0] mask, ea, eb, full, part, m;
    logic c;
    mask = (64'd1 << w) - 64'd1;
    ea   = {32'd0, a} & mask;
    eb   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    c    = sub | cin;
    full = ea + eb + 64'(c);
    r.s  = 32'(full & mask);
    r.co = full[w];
    r.ov = (ea[w-1] == eb[w-1]) && (full[w-1] != ea[w-1]);
    r.bc = '0;
    for (int unsigned i = 0; i < w / blk; i++) begin
      m    = (64'd1 << ((i + 1) * blk)) - 64'd1;
      part = (ea & m) + (eb & m) + 64'(c);
      r.bc[i] = part[(i + 1) * blk];
    end
    return r;
  endfunction

  task automatic run_stream(input bit wide, input int nops, input bit pat);
    exp_t        q[$];
    exp_t        h;
    int          sent, got, iter, first_valid;
    logic [31:0] va, vb, act_s;
    logic        vc, vs, rdy, iv, prev_stall, ov_o, ir_o, co_o, of_o;
    logic [3:0]  bc_o;
    sent = 0; got = 0; iter = 0; first_valid = -1; prev_stall = 1'b0;
    while (got < nops && iter < 8 * nops + 50) begin
      @(negedge clk);
      va  = $urandom;
      vb  = $urandom;
      vc  = 1'($urandom_range(0, 1));
      vs  = 1'($urandom_range(0, 1));
      rdy = pat ? ((iter % 4) == 0 || (iter % 4) == 3) : ($urandom_range(0, 3) != 0);
      iv  = (sent < nops);
      if (wide) begin
        w_a = va; w_b = vb; w_cin = vc; w_sub = vs; w_in_valid = iv; w_out_ready = rdy;
      end else begin
        n_a = va[15:0]; n_b = vb[15:0]; n_cin = vc; n_sub = vs; n_in_valid = iv; n_out_ready = rdy;
      end
      #1;
      if (wide) begin
        ov_o = w_out_valid; ir_o = w_in_ready; act_s = w_sum; co_o = w_co; of_o = w_ov; bc_o = w_bc;
      end else begin
        ov_o = n_out_valid; ir_o = n_in_ready; act_s = {16'd0, n_sum}; co_o = n_co; of_o = n_ov; bc_o = n_bc;
      end
      chk("stream_in_ready", ir_o, !(ov_o && !rdy));
      if (prev_stall) chk("stall_valid_held", ov_o, 1'b1);
      if (ov_o && first_valid < 0) first_valid = iter;
      if (ov_o) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_result", 1'b1, 1'b0);
        end else begin
          // Head of the queue must be shown every cycle, stalled or not.
          h = q[0];
          chk("stream_sum", act_s, h.s);
          chk("stream_carry_out", co_o, h.co);
          chk("stream_overflow", of_o, h.ov);
          chk("stream_block_carries", bc_o, h.bc[3:0]);
          if (rdy) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (iv && ir_o) begin
        q.push_back(model(wide ? 32 : 16, wide ? 8 : 4, va, vb, vc, vs));
        sent++;
      end
      prev_stall = ov_o && !rdy;
      iter++;
    end
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    chk("stream_all_results", 64'(got), 64'(nops));
    if (pat) chk("stream_first_result_iter", 64'(first_valid), 64'd4);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{16'd10,    16'd11,    1'b0, 1'b0, 16'd21,    1'b0, 1'b0, 4'b0001};
    vecs[1] = '{16'd10,    16'd11,    1'b1, 1'b0, 16'd22,    1'b0, 1'b0, 4'b0001};
    vecs[2] = '{16'hFFFF,  16'h0001,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b0, 4'b1111};
    vecs[3] = '{16'h7FFF,  16'h0001,  1'b0, 1'b0, 16'h8000,  1'b0, 1'b1, 4'b0111};
    vecs[4] = '{16'h0005,  16'h0007,  1'b0, 1'b1, 16'hFFFE,  1'b0, 1'b0, 4'b0000};
    vecs[5] = '{16'h8000,  16'h0001,  1'b0, 1'b1, 16'h7FFF,  1'b1, 1'b1, 4'b1000};
    vecs[6] = '{16'h0005,  16'h0007,  1'b1, 1'b1, 16'hFFFE,  1'b0, 1'b0, 4'b0000};
    vecs[7] = '{16'h0007,  16'h0005,  1'b0, 1'b1, 16'h0002,  1'b1, 1'b0, 4'b1111};
    vecs[8] = '{16'h1234,  16'h4321,  1'b0, 1'b0, 16'h5555,  1'b0, 1'b0, 4'b0000};
    vecs[9] = '{16'h8000,  16'h8000,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b1, 4'b1000};

    rst = 1'b1;
    n_in_valid = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0; n_sub = 1'b0; n_out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", n_out_valid, 1'b0);
    chk("reset_sum", n_sum, 16'd0);
    chk("reset_carry_out", n_co, 1'b0);
    chk("reset_overflow", n_ov, 1'b0);
    chk("reset_block_carries", n_bc, 4'd0);
    chk("reset_wide_out_valid", w_out_valid, 1'b0);
    #1 chk("reset_in_ready", n_in_ready, 1'b1);

    // Single operations through the default pipeline, latency 4.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      n_a = vecs[i].a; n_b = vecs[i].b; n_cin = vecs[i].cin; n_sub = vecs[i].sub;
      n_in_valid = 1'b1; n_out_ready = 1'b1;
      #1 chk($sformatf("vec%0d_in_ready", i), n_in_ready, 1'b1);
      @(negedge clk);
      n_in_valid = 1'b0;
      chk($sformatf("vec%0d_valid_k0", i), n_out_valid, 1'b0);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_valid_k2", i), n_out_valid, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_k3", i), n_out_valid, 1'b1);
      chk($sformatf("vec%0d_sum", i), n_sum, vecs[i].s);
      chk($sformatf("vec%0d_carry_out", i), n_co, vecs[i].co);
      chk($sformatf("vec%0d_overflow", i), n_ov, vecs[i].ov);
      chk($sformatf("vec%0d_block_carries", i), n_bc, vecs[i].bc);
    end

    // Wide instance, L=2: all-ones plus one.
    @(negedge clk);
    w_a = 32'hFFFF_FFFF; w_b = 32'h0000_0001; w_cin = 1'b0; w_sub = 1'b0;
    w_in_valid = 1'b1; w_out_ready = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    chk("wide_valid_k0", w_out_valid, 1'b0);
    @(negedge clk);
    chk("wide_valid_k1", w_out_valid, 1'b1);
    chk("wide_sum", w_sum, 32'd0);
    chk("wide_carry_out", w_co, 1'b1);
    chk("wide_overflow", w_ov, 1'b0);
    chk("wide_block_carries", w_bc, 4'b1111);

    // Back-to-back stream with out_ready pattern 1,0,0,1.
    run_stream(1'b0, 8, 1'b1);

    // Reset with three operations in flight.
    @(negedge clk);
    n_a = 16'h1111; n_b = 16'h1111; n_cin = 1'b0; n_sub = 1'b0; n_in_valid = 1'b1; n_out_ready = 1'b1;
    @(negedge clk);
    n_a = 16'h2222; n_b = 16'h2222;
    @(negedge clk);
    n_a = 16'h3333; n_b = 16'h3333;
    @(negedge clk);
    rst = 1'b1; n_a = 16'h4444; n_b = 16'h4444;
    @(negedge clk);
    rst = 1'b0; n_a = 16'h0100; n_b = 16'h0023;
    chk("flush_out_valid", n_out_valid, 1'b0);
    #1 chk("flush_in_ready", n_in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_in_valid = 1'b0;
      chk($sformatf("flush_no_stale_%0d", i), n_out_valid, 1'b0);
    end
    @(negedge clk);
    chk("flush_next_valid", n_out_valid, 1'b1);
    chk("flush_next_sum", n_sum, 16'h0123);
    chk("flush_next_block_carries", n_bc, 4'b0000);
    @(negedge clk);
    chk("flush_no_duplicate", n_out_valid, 1'b0);

    // Wide instance: 1000 random operations with random back-pressure.
    run_stream(1'b1, 1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
